instr_decode_rle: RTL and testbench

- Sequential successor to the brainfuck instruction decoder.
- Accepts a byte stream of program characters over a valid/ready handshake and decodes each byte into the nine one-hot command classes.
- Run-length merges consecutive `+ - < >` into a single (op, count) token, and optionally cancels opposing pairs.
- Sits between program fetch and the execute unit, so the datapath applies `dp += n` / `*dp += n` in one step.

---
 rtl/instr_decode_rle.sv | 187 ++++++++++++++++++
 tb/tb_instr_decode_rle.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_rle.sv
// ----------------------------------------------------------------------------
// instr_decode_rle
//   Streaming brainfuck decoder with run-length merging. Each accepted program
//   byte is decoded into one of nine one-hot command classes. Runs of the
//   mergeable ops (> < + -) collapse into one (op, count) token, and opposing
//   ops can cancel against a pending run, so the execute unit can apply
//   `dp += n` or `*dp += n` in a single step.
//
//   Two register stages: an accumulator holding the run being built, and an
//   output register holding the token offered downstream.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   in_data    in   [7:0] ASCII program byte
//   in_valid   in   in_data valid
//   in_ready   out  byte accepted when in_valid && in_ready at the clk edge
//   flush      in   level, end of stream: pushes out the pending run
//   out_op     out  [8:0] one-hot {nop, loop_end, loop_start, in_d, out_d,
//                   dec_d, inc_d, dec_dp, inc_dp}
//   out_cnt    out  [CNT_W-1:0] run count, >= 1 whenever out_valid
//   out_valid  out  token valid
//   out_ready  in   token consumed when out_valid && out_ready
//   idle       out  nothing pending in either stage
// ----------------------------------------------------------------------------
module instr_decode_rle #(
    parameter int CNT_W    = 8,
    parameter bit CANCEL   = 1'b1,
    parameter bit DROP_NOP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [8:0]       out_op,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             idle
);

    localparam logic [8:0] OP_INC_DP     = 9'b0_0000_0001;
    localparam logic [8:0] OP_DEC_DP     = 9'b0_0000_0010;
    localparam logic [8:0] OP_INC_D      = 9'b0_0000_0100;
    localparam logic [8:0] OP_DEC_D      = 9'b0_0000_1000;
    localparam logic [8:0] OP_OUT_D      = 9'b0_0001_0000;
    localparam logic [8:0] OP_IN_D       = 9'b0_0010_0000;
    localparam logic [8:0] OP_LOOP_START = 9'b0_0100_0000;
    localparam logic [8:0] OP_LOOP_END   = 9'b0_1000_0000;
    localparam logic [8:0] OP_NOP        = 9'b1_0000_0000;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [8:0] decode_op(input logic [7:0] ch);
        logic [8:0] op;
        case (ch)
            8'h3E:   op = OP_INC_DP;
            8'h3C:   op = OP_DEC_DP;
            8'h2B:   op = OP_INC_D;
            8'h2D:   op = OP_DEC_D;
            8'h2E:   op = OP_OUT_D;
            8'h2C:   op = OP_IN_D;
            8'h5B:   op = OP_LOOP_START;
            8'h5D:   op = OP_LOOP_END;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

    // Swapping the inc/dec bits of each mergeable pair yields the op that cancels it.
    function automatic logic [8:0] opposite_op(input logic [8:0] op);
        return {op[8:4], op[2], op[3], op[0], op[1]};
    endfunction

    function automatic logic is_mergeable(input logic [8:0] op);
        return |op[3:0];
    endfunction

    logic             acc_valid_r, acc_valid_n;
    logic [8:0]       acc_op_r,    acc_op_n;
    logic [CNT_W-1:0] acc_cnt_r,   acc_cnt_n;
    logic             out_valid_r, out_valid_n;
    logic [8:0]       out_op_r,    out_op_n;
    logic [CNT_W-1:0] out_cnt_r,   out_cnt_n;

    logic [8:0] in_op_s;
    logic       slot_free_s;
    logic       drop_s;
    logic       load_s;
    logic       merge_s;
    logic       cancel_s;
    logic       accept_s;
    logic       drain_s;
    logic       move_s;

    assign in_op_s     = decode_op(in_data);
    assign slot_free_s = !out_valid_r || out_ready;

    // Byte classes, evaluated independently; priority is applied in the next-state logic.
    assign drop_s   = DROP_NOP && in_op_s[8];
    assign load_s   = !acc_valid_r;
    assign merge_s  = acc_valid_r && (in_op_s == acc_op_r) && is_mergeable(in_op_s)
                      && (acc_cnt_r != CNT_MAX);
    assign cancel_s = CANCEL && acc_valid_r && is_mergeable(acc_op_r)
                      && (in_op_s == opposite_op(acc_op_r));

    // Only the "emit and reload" case depends on room in the output register.
    assign in_ready = !flush && (drop_s || load_s || merge_s || cancel_s || slot_free_s);
    assign accept_s = in_valid && in_ready;

    // Single ops never wait for company; runs leave only on flush or via move below.
    assign drain_s = acc_valid_r && slot_free_s && (flush || !is_mergeable(acc_op_r));
    assign move_s  = drain_s || (accept_s && !drop_s && !load_s && !merge_s && !cancel_s);

    assign out_op    = out_op_r;
    assign out_cnt   = out_cnt_r;
    assign out_valid = out_valid_r;
    assign idle      = !acc_valid_r && !out_valid_r;

    // Next-state logic for both register stages.
    always_comb begin
        acc_valid_n = acc_valid_r;
        acc_op_n    = acc_op_r;
        acc_cnt_n   = acc_cnt_r;
        out_valid_n = out_valid_r;
        out_op_n    = out_op_r;
        out_cnt_n   = out_cnt_r;

        if (move_s) begin
            out_valid_n = 1'b1;
            out_op_n    = acc_op_r;
            out_cnt_n   = acc_cnt_r;
        end else if (out_valid_r && out_ready) begin
            out_valid_n = 1'b0;
        end else begin
            out_valid_n = out_valid_r;
        end

        if (accept_s && !drop_s) begin
            if (merge_s && !load_s) begin
                acc_cnt_n = acc_cnt_r + CNT_ONE;
            end else if (cancel_s && !load_s) begin
                if (acc_cnt_r == CNT_ONE) begin
                    acc_valid_n = 1'b0;
                    acc_op_n    = 9'b0_0000_0000;
                    acc_cnt_n   = {CNT_W{1'b0}};
                end else begin
                    acc_cnt_n = acc_cnt_r - CNT_ONE;
                end
            end else begin
                // Empty acc, or the old contents just moved out this cycle.
                acc_valid_n = 1'b1;
                acc_op_n    = in_op_s;
                acc_cnt_n   = CNT_ONE;
            end
        end else if (move_s) begin
            acc_valid_n = 1'b0;
            acc_op_n    = 9'b0_0000_0000;
            acc_cnt_n   = {CNT_W{1'b0}};
        end else begin
            acc_valid_n = acc_valid_r;
        end
    end

    // State registers with asynchronous reset discarding any pending run or token.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_valid_r <= 1'b0;
            acc_op_r    <= 9'b0_0000_0000;
            acc_cnt_r   <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_op_r    <= 9'b0_0000_0000;
            out_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            acc_valid_r <= acc_valid_n;
            acc_op_r    <= acc_op_n;
            acc_cnt_r   <= acc_cnt_n;
            out_valid_r <= out_valid_n;
            out_op_r    <= out_op_n;
            out_cnt_r   <= out_cnt_n;
        end
    end

endmodule

// File: tb/tb_instr_decode_rle.sv
// ----------------------------------------------------------------------------
// tb_instr_decode_rle
//   Bench for instr_decode_rle. Two instances share the stimulus: dut_a uses
//   the default parameters (CNT_W=8, CANCEL=1, DROP_NOP=1), dut_b uses
//   CNT_W=2, CANCEL=0, DROP_NOP=0. `sel` picks which one is observed.
//   Expected tokens are queued as stimulus is driven; a monitor collects every
//   consumed token, and each test pops and compares both queues.
// ----------------------------------------------------------------------------
module tb_instr_decode_rle;

    localparam logic [8:0] T_INC_DP     = 9'h001;
    localparam logic [8:0] T_DEC_DP     = 9'h002;
    localparam logic [8:0] T_INC_D      = 9'h004;
    localparam logic [8:0] T_DEC_D      = 9'h008;
    localparam logic [8:0] T_OUT_D      = 9'h010;
    localparam logic [8:0] T_LOOP_START = 9'h040;
    localparam logic [8:0] T_LOOP_END   = 9'h080;
    localparam logic [8:0] T_NOP        = 9'h100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b1;
    logic       sel = 1'b0;

    logic       a_in_ready, a_valid, a_idle;
    logic [8:0] a_op;
    logic [7:0] a_cnt;
    logic       b_in_ready, b_valid, b_idle;
    logic [8:0] b_op;
    logic [1:0] b_cnt;

    logic       m_ready, m_valid, m_idle;
    logic [8:0] m_op;
    logic [7:0] m_cnt;

    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    logic [16:0] e_tok, g_tok;
    int n_vec = 0;
    int n_err = 0;

    instr_decode_rle dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .flush(flush), .out_op(a_op), .out_cnt(a_cnt),
        .out_valid(a_valid), .out_ready(out_ready), .idle(a_idle)
    );

    instr_decode_rle #(.CNT_W(2), .CANCEL(1'b0), .DROP_NOP(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .flush(flush), .out_op(b_op), .out_cnt(b_cnt),
        .out_valid(b_valid), .out_ready(out_ready), .idle(b_idle)
    );

    assign m_ready = sel ? b_in_ready : a_in_ready;
    assign m_valid = sel ? b_valid : a_valid;
    assign m_idle  = sel ? b_idle : a_idle;
    assign m_op    = sel ? b_op : a_op;
    assign m_cnt   = sel ? {6'b000000, b_cnt} : a_cnt;

    always #5 clk = ~clk;

    // Collect every token the observed DUT hands over.
    always @(posedge clk) begin
        if (rst_n && m_valid && out_ready) got_q.push_back({m_op, m_cnt});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [8:0] op, input logic [7:0] cnt);
        exp_q.push_back({op, cnt});
    endtask

    task automatic apply_reset(input logic which);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; sel = which;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete(); got_q.delete();
    endtask

    // Present one byte and hold it until the observed DUT accepts it.
    task automatic send(input logic [7:0] ch);
        logic r, done;
        done = 1'b0;
        @(negedge clk);
        in_data = ch; in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            #2 r = m_ready;
            @(posedge clk);
            if (r) done = 1'b1;
            else @(negedge clk);
        end
        #1 in_valid = 1'b0;
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL send_accept byte %h never accepted (in_ready stuck 0), required acceptance", ch);
        end
    endtask

    // Wait (bounded) until the observed DUT is idle, optionally holding flush.
    task automatic drain(input logic use_flush);
        logic done;
        done = 1'b0;
        @(negedge clk);
        flush = use_flush;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (m_idle) done = 1'b1;
        end
        flush = 1'b0;
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL drain_idle idle=%b, required 1 within 200 cycles", m_idle);
        end
    endtask

    task automatic test_reset();
        apply_reset(1'b0);
        out_ready = 1'b1;
        #1;
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", m_valid); end
        n_vec++; if (m_idle !== 1'b1) begin n_err++; $display("FAIL rst_idle got %b want 1", m_idle); end
        n_vec++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", m_ready); end
        n_vec++; if ({m_op, m_cnt} !== 17'h0) begin n_err++; $display("FAIL rst_out_tok got %h want 0", {m_op, m_cnt}); end
        repeat (3) send("+");
        @(negedge clk);
        n_vec++; if (m_idle !== 1'b0) begin n_err++; $display("FAIL run_pending_idle got %b want 0", m_idle); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (m_valid !== 1'b0 || m_idle !== 1'b1) begin
            n_err++; $display("FAIL async_rst valid=%b idle=%b want valid=0 idle=1", m_valid, m_idle);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got %b want 1", m_ready); end
        flush = 1'b1;
        repeat (6) @(negedge clk);
        flush = 1'b0;
        n_vec++; if (got_q.size() !== 0 || m_idle !== 1'b1) begin
            n_err++; $display("FAIL post_rst_no_token tokens=%0d idle=%b want 0 tokens idle=1", got_q.size(), m_idle);
        end
    endtask

    task automatic test_merge();
        apply_reset(1'b0);
        out_ready = 1'b1;
        push_exp(T_INC_D, 8'd3); push_exp(T_INC_DP, 8'd2);
        send("+"); send("+"); send("+"); send(">"); send(">");
        drain(1'b1);
        n_vec++; if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL merge_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e_tok = exp_q.pop_front(); g_tok = got_q.pop_front(); n_vec++;
            if (g_tok !== e_tok) begin n_err++; $display("FAIL merge_tok got %h want %h", g_tok, e_tok); end
        end
    endtask

    task automatic test_single_ops();
        apply_reset(1'b0);
        out_ready = 1'b1;
        push_exp(T_LOOP_START, 8'd1); push_exp(T_OUT_D, 8'd1); push_exp(T_LOOP_END, 8'd1);
        send("[");
        // Cycle after acceptance: token still in the accumulator.
        #1;
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL latency_early out_valid got %b want 0", m_valid); end
        @(posedge clk); #1;
        n_vec++; if (m_valid !== 1'b1 || m_op !== T_LOOP_START || m_cnt !== 8'd1) begin
            n_err++; $display("FAIL latency_2cyc valid=%b op=%h cnt=%0d want 1 %h 1", m_valid, m_op, m_cnt, T_LOOP_START);
        end
        send("."); send("]");
        drain(1'b0);
        n_vec++; if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL single_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e_tok = exp_q.pop_front(); g_tok = got_q.pop_front(); n_vec++;
            if (g_tok !== e_tok) begin n_err++; $display("FAIL single_tok got %h want %h", g_tok, e_tok); end
        end
    endtask

    task automatic test_saturation();
        apply_reset(1'b1);
        out_ready = 1'b1;
        push_exp(T_DEC_D, 8'd3); push_exp(T_DEC_D, 8'd3); push_exp(T_DEC_D, 8'd1);
        repeat (7) send("-");
        drain(1'b1);
        n_vec++; if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL sat_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e_tok = exp_q.pop_front(); g_tok = got_q.pop_front(); n_vec++;
            if (g_tok !== e_tok) begin n_err++; $display("FAIL sat_tok got %h want %h", g_tok, e_tok); end
        end
    endtask

    task automatic test_cancel();
        apply_reset(1'b0);
        out_ready = 1'b1;
        push_exp(T_INC_D, 8'd1); push_exp(T_DEC_DP, 8'd1);
        send("+"); send("+"); send("-"); send("x"); send("<");
        drain(1'b1);
        send("+"); send("-");
        #1;
        n_vec++; if (m_idle !== 1'b1) begin n_err++; $display("FAIL cancel_pair idle got %b want 1", m_idle); end
        push_exp(T_DEC_D, 8'd1);
        send("-");
        drain(1'b1);
        n_vec++; if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL cancel_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e_tok = exp_q.pop_front(); g_tok = got_q.pop_front(); n_vec++;
            if (g_tok !== e_tok) begin n_err++; $display("FAIL cancel_tok got %h want %h", g_tok, e_tok); end
        end
        // No cancelling, nops kept as tokens.
        apply_reset(1'b1);
        push_exp(T_INC_D, 8'd2); push_exp(T_DEC_D, 8'd1); push_exp(T_NOP, 8'd1); push_exp(T_DEC_DP, 8'd1);
        send("+"); send("+"); send("-"); send("x"); send("<");
        drain(1'b1);
        n_vec++; if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL nocancel_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e_tok = exp_q.pop_front(); g_tok = got_q.pop_front(); n_vec++;
            if (g_tok !== e_tok) begin n_err++; $display("FAIL nocancel_tok got %h want %h", g_tok, e_tok); end
        end
    endtask

    task automatic test_backpressure();
        apply_reset(1'b0);
        out_ready = 1'b0;
        push_exp(T_INC_D, 8'd1); push_exp(T_INC_DP, 8'd1); push_exp(T_LOOP_START, 8'd1);
        send("+"); send(">");
        @(negedge clk);
        in_data = "["; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            n_vec++; if (m_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", m_ready); end
            n_vec++; if (m_valid !== 1'b1 || m_op !== T_INC_D || m_cnt !== 8'd1) begin
                n_err++; $display("FAIL bp_hold valid=%b op=%h cnt=%0d want 1 %h 1", m_valid, m_op, m_cnt, T_INC_D);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        send("[");
        drain(1'b0);
        n_vec++; if (got_q.size() !== exp_q.size()) begin
            n_err++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e_tok = exp_q.pop_front(); g_tok = got_q.pop_front(); n_vec++;
            if (g_tok !== e_tok) begin n_err++; $display("FAIL bp_tok got %h want %h", g_tok, e_tok); end
        end
    endtask

    initial begin
        test_reset();
        test_merge();
        test_single_ops();
        test_saturation();
        test_cancel();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
